fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'hBFC00000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall  input  1  decode cannot accept; if_* held while high.
REQ-005 redirect_valid  input  1  EX-stage control-flow redirect this cycle.
REQ-006 redirect_sel  input  2  01 = redirect_pc + redirect_imm (branch/JAL); 10 = {redirect_alu[31:1],1'b0} (JALR); 00/11 = no redirect.
REQ-007 redirect_pc  input  32  PC of redirecting instruction.
REQ-008 redirect_imm  input  32  sign-extended immediate.
REQ-009 redirect_alu  input  32  rs1+imm from ALU.
REQ-010 imem_req  output  1  fetch request; held until imem_ack.
REQ-011 imem_addr  output  32  fetch address; stable while imem_req high.
REQ-012 imem_ack  input  1  response valid; may arrive same cycle as first imem_req; meaningful only while imem_req high.
REQ-013 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-014 if_valid / if_pc / if_instr  output  1/32/32  registered fetch output to decode.
REQ-015 misalign_err  output  1  one-cycle pulse: accepted redirect target has bit1 set.
REQ-016 fetch_count  output  32  instructions delivered (if_valid & !stall), wraps.

Function
REQ-017 States: IDLE, FETCH, DROP; internal registers pc (next fetch address), drop_addr.
REQ-018 IDLE: imem_req=0; next state FETCH unconditionally (one cycle after reset release).
REQ-019 FETCH: imem_addr=pc; imem_req=1 only when output slot free (!if_valid or !stall); otherwise imem_req=0, pc unchanged.
REQ-020 FETCH, imem_ack, no redirect: next cycle if_valid=1, if_pc=pc, if_instr=imem_rdata; pc<=pc+4 (mod 2^32).
REQ-021 Consumption: if_valid & !stall with no new ack -> if_valid<=0; fetch_count+=1 on every consumption.
REQ-022 Accepted redirect = redirect_valid & sel in {01,10}; target per REQ-006 (add mod 2^32); sel 00/11 ignored entirely.
REQ-023 Accepted redirect has priority over stall and ack: if_valid<=0 (flush, not counted), pc<=target.
REQ-024 Redirect in FETCH with imem_req=1 and imem_ack=0: drop_addr<=pc; state<=DROP (in-flight request must complete).
REQ-025 Redirect in FETCH with imem_ack=1 same cycle, or with imem_req=0: response discarded; stay FETCH.
REQ-026 DROP: imem_req=1, imem_addr=drop_addr; on imem_ack, data discarded, if_valid stays 0, state<=FETCH.
REQ-027 Redirect during DROP: pc<=new target; stay DROP (or FETCH if ack same cycle); drop_addr unchanged.
REQ-028 misalign_err=1 the cycle after an accepted redirect whose target[1]=1; target still used.
REQ-029 At most one request outstanding at any time.

Reset
REQ-030 rst high at a clock edge: state=IDLE, pc=RESET_VECTOR, imem_req=0, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, fetch_count=0.
REQ-031 rst mid-DROP or mid-request overrides all; no ack tracked after reset; external memory reset with same rst.

Verification
REQ-032 Reset release, ack every cycle, stall=0 -> imem_addr BFC00000, BFC00004, BFC00008; if_pc follows one cycle later; fetch_count increments per cycle.
REQ-033 Stall asserted with if_valid=1 for 3 cycles -> if_pc/if_instr constant, imem_req=0, fetch_count unchanged; resumes at pc+4 on release.
REQ-034 Redirect sel=01, redirect_pc=BFC00010, imm=FFFFFFF0 with ack same cycle -> if_valid=0 next cycle, next imem_addr=BFC00000.
REQ-035 Ack latency 3; redirect sel=10, alu=80000007 in first wait cycle -> imem_addr held at old address until ack (DROP), data discarded, then imem_addr=80000006, misalign_err pulses once.
REQ-036 Redirect with sel=11 -> no effect; redirect and stall together -> flush wins, if_valid=0; rst asserted during DROP -> IDLE, imem_addr=BFC00000 two cycles later.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and
// the instruction memory.
//
// Signals:
//   imem_req   - fetch request, held until imem_ack
//   imem_addr  - fetch address, stable while imem_req is high
//   imem_ack   - response valid (may coincide with the first imem_req cycle)
//   imem_rdata - instruction word, valid with imem_ack
//
// Modports:
//   master - fetch sequencer side (drives req/addr)
//   slave  - memory side (drives ack/rdata)
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory request at a
// time, registers the fetched word for decode, and applies EX redirects.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   imem            - instruction memory bus (master modport)
//   stall           - decode cannot accept; the if_* outputs are held
//   redirect_*      - EX-stage redirect (sel 01: pc+imm, 10: alu & ~1)
//   if_valid/pc/instr - registered fetch output to decode
//   misalign_err    - one-cycle pulse, accepted redirect target bit1 set
//   fetch_count     - instructions delivered to decode (wraps)
//
// Parameter:
//   RESET_VECTOR    - first fetch address after reset
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,

    fetch_sequencer_if.master     imem,

    input  logic                  stall,

    input  logic                  redirect_valid,
    input  logic [1:0]            redirect_sel,
    input  logic [31:0]           redirect_pc,
    input  logic [31:0]           redirect_imm,
    input  logic [31:0]           redirect_alu,

    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_instr,
    output logic                  misalign_err,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redir_acc;
    logic [31:0] redir_target;
    logic        slot_free;
    logic        consume;
    logic        req;
    logic [31:0] addr;
    logic        ack_v;

    // JALR target drops bit 0 of the ALU sum.
    logic        unused_alu_lsb;
    assign unused_alu_lsb = redirect_alu[0];

    // Only sel 01 and 10 are real redirects; 00/11 are ignored.
    always_comb begin
        redir_acc    = 1'b0;
        redir_target = pc_q;
        if (redirect_valid) begin
            unique case (redirect_sel)
                2'b01: begin
                    redir_acc    = 1'b1;
                    redir_target = redirect_pc + redirect_imm;
                end
                2'b10: begin
                    redir_acc    = 1'b1;
                    redir_target = {redirect_alu[31:1], 1'b0};
                end
                default: begin
                    redir_acc    = 1'b0;
                    redir_target = pc_q;
                end
            endcase
        end
    end

    // The output register can take a new word if it is empty or being
    // consumed this cycle.
    assign slot_free = !if_valid_q || !stall;
    assign consume   = if_valid_q && !stall;

    // Request and address generation.
    always_comb begin
        req  = 1'b0;
        addr = pc_q;
        unique case (state_q)
            S_IDLE: begin
                req  = 1'b0;
                addr = pc_q;
            end
            S_FETCH: begin
                req  = slot_free;
                addr = pc_q;
            end
            S_DROP: begin
                req  = 1'b1;
                addr = drop_addr_q;
            end
            default: begin
                req  = 1'b0;
                addr = pc_q;
            end
        endcase
    end

    // An ack only counts while a request is actually outstanding.
    assign ack_v = imem.imem_ack && req;

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        misalign_d    = redir_acc && redir_target[1];
        fetch_count_d = fetch_count_q;

        // Delivery to decode; a flushed slot is not counted.
        if (consume && !redir_acc) begin
            if_valid_d    = 1'b0;
            fetch_count_d = fetch_count_q + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redir_acc) begin
                    pc_d       = redir_target;
                    if_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (redir_acc) begin
                    pc_d       = redir_target;
                    if_valid_d = 1'b0;
                    // A request still in flight must be allowed to finish
                    // before fetching from the new target.
                    if (req && !ack_v) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (ack_v) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem.imem_rdata;
                    pc_d       = pc_q + 32'd4;
                end
            end
            S_DROP: begin
                if (redir_acc) begin
                    pc_d       = redir_target;
                    if_valid_d = 1'b0;
                end
                if (ack_v) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            drop_addr_q   <= 32'd0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_instr_q    <= 32'd0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    assign if_valid     = if_valid_q;
    assign if_pc        = if_pc_q;
    assign if_instr     = if_instr_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a variable-latency
// instruction memory model (rdata = ~addr).
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_imm;
    logic [31:0] redirect_alu;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks;
    int errors;
    int lat;
    int cnt;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_VECTOR (32'hBFC00000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .redirect_pc    (redirect_pc),
        .redirect_imm   (redirect_imm),
        .redirect_alu   (redirect_alu),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks once the request has been held for lat cycles.
    always @(posedge clk) begin
        if (rst || !bus.imem_req || bus.imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end
    assign bus.imem_ack   = bus.imem_req && (cnt >= lat);
    assign bus.imem_rdata = ~bus.imem_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        lat = 0;
        cnt = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_sel = 2'b00;
        redirect_pc = 32'd0;
        redirect_imm = 32'd0;
        redirect_alu = 32'd0;

        tick();
        tick();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

        // Streaming fetch, ack every cycle
        rst = 1'b0;
        tick();
        chk("idle_to_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("addr0", bus.imem_addr, 32'hBFC00000);
        tick();
        chk("pc0", if_pc, 32'hBFC00000);
        chk("instr0", if_instr, ~32'hBFC00000);
        chk("addr1", bus.imem_addr, 32'hBFC00004);
        chk("count0", fetch_count, 32'd0);
        tick();
        chk("pc1", if_pc, 32'hBFC00004);
        chk("addr2", bus.imem_addr, 32'hBFC00008);
        chk("count1", fetch_count, 32'd1);
        tick();
        chk("pc2", if_pc, 32'hBFC00008);
        chk("count2", fetch_count, 32'd2);

        // Stall for three cycles
        stall = 1'b1;
        #1;
        chk("stall_req_now", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", if_pc, 32'hBFC00008);
            chk("stall_instr", if_instr, ~32'hBFC00008);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("resume_pc", if_pc, 32'hBFC0000C);
        chk("resume_count", fetch_count, 32'd3);
        chk("resume_addr", bus.imem_addr, 32'hBFC00010);

        // Branch redirect with same-cycle ack
        redirect_valid = 1'b1;
        redirect_sel = 2'b01;
        redirect_pc = 32'hBFC00010;
        redirect_imm = 32'hFFFFFFF0;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("br_flush", {31'd0, if_valid}, 32'd0);
        chk("br_addr", bus.imem_addr, 32'hBFC00000);
        chk("br_count", fetch_count, 32'd3);
        chk("br_misalign", {31'd0, misalign_err}, 32'd0);
        tick();
        chk("br_pc", if_pc, 32'hBFC00000);
        chk("br_valid", {31'd0, if_valid}, 32'd1);

        // sel=11 is ignored
        redirect_valid = 1'b1;
        redirect_sel = 2'b11;
        redirect_alu = 32'h12345678;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("sel11_pc", if_pc, 32'hBFC00004);
        chk("sel11_count", fetch_count, 32'd4);
        chk("sel11_addr", bus.imem_addr, 32'hBFC00008);
        chk("sel11_mis", {31'd0, misalign_err}, 32'd0);

        // Latency 3, JALR redirect while waiting
        lat = 3;
        tick();
        chk("wait_valid", {31'd0, if_valid}, 32'd0);
        chk("wait_count", fetch_count, 32'd5);
        chk("wait_ack", {31'd0, bus.imem_ack}, 32'd0);
        redirect_valid = 1'b1;
        redirect_sel = 2'b10;
        redirect_alu = 32'h80000007;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drop_mis", {31'd0, misalign_err}, 32'd1);
        chk("drop_addr", bus.imem_addr, 32'hBFC00008);
        chk("drop_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
        chk("drop_mis_once", {31'd0, misalign_err}, 32'd0);
        chk("drop_addr_hold", bus.imem_addr, 32'hBFC00008);
        chk("drop_ack", {31'd0, bus.imem_ack}, 32'd1);
        tick();
        chk("drop_discard", {31'd0, if_valid}, 32'd0);
        chk("jalr_addr", bus.imem_addr, 32'h80000006);
        tick();
        tick();
        tick();
        chk("jalr_wait_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("jalr_pc", if_pc, 32'h80000006);
        chk("jalr_instr", if_instr, ~32'h80000006);
        chk("jalr_count", fetch_count, 32'd5);

        // Redirect together with stall: flush wins
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_sel = 2'b01;
        redirect_pc = 32'h00001000;
        redirect_imm = 32'h00000100;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
        chk("rs_flush", {31'd0, if_valid}, 32'd0);
        chk("rs_count", fetch_count, 32'd5);
        chk("rs_addr", bus.imem_addr, 32'h00001100);

        // Reset during DROP
        redirect_valid = 1'b1;
        redirect_sel = 2'b01;
        redirect_pc = 32'h00000000;
        redirect_imm = 32'h00000200;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_drop_addr", bus.imem_addr, 32'h00001100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rd_idle_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rd_count", fetch_count, 32'd0);
        tick();
        chk("rd_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rd_addr", bus.imem_addr, 32'hBFC00000);
        lat = 0;
        tick();
        chk("rd_pc", if_pc, 32'hBFC00000);
        chk("rd_valid", {31'd0, if_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
